// File: rtl/calendar_date_ctrl.sv
// Calendar date controller: tracks day/month/year 0001..9999, advances on a
// tick and loads a new date through a multi-cycle divide-by-subtraction check.
// set_req/tick are single-cycle pulses sampled only in RUN; busy is high from
// the cycle after an accepted set_req until the cycle set_ack/set_err pulses,
// and any pulse arriving while busy is dropped.
module calendar_date_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        set_req,
    input  logic [4:0]  set_day,
    input  logic [3:0]  set_month,
    input  logic [13:0] set_year,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [13:0] year,
    output logic [5:0]  dim,
    output logic        leap,
    output logic        busy,
    output logic        set_ack,
    output logic        set_err,
    output logic        month_wrap,
    output logic        year_wrap
);

    typedef enum logic [1:0] {RUN, DIV400, DIV100, CHECK} state_t;

    function automatic logic [5:0] days_in_month(input logic [3:0] m, input logic lp);
        case (m)
            4'd2:                      return lp ? 6'd29 : 6'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 6'd30;
            default:                   return 6'd31;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  day_q, day_d;
    logic [3:0]  month_q, month_d;
    logic [13:0] year_q, year_d;
    logic [8:0]  r400_q, r400_d;
    logic [6:0]  r100_q, r100_d;
    logic [4:0]  sd_q, sd_d;
    logic [3:0]  sm_q, sm_d;
    logic [13:0] sy_q, sy_d;
    logic [13:0] sr_q, sr_d;
    logic [8:0]  s400_q, s400_d;
    logic [6:0]  s100_q, s100_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        mw_q, mw_d;
    logic        yw_q, yw_d;

    logic        s_leap;
    logic        s_valid;

    // Current-date leap/dim come straight from the residue registers.
    assign leap = (year_q[1:0] == 2'd0) && ((r100_q != 7'd0) || (r400_q == 9'd0));
    assign dim  = days_in_month(month_q, leap);

    // Shadow date validation, using residues produced by the subtract loops.
    assign s_leap  = (sy_q[1:0] == 2'd0) && ((s100_q != 7'd0) || (s400_q == 9'd0));
    assign s_valid = (sm_q >= 4'd1) && (sm_q <= 4'd12) &&
                     (sy_q >= 14'd1) && (sy_q <= 14'd9999) &&
                     (sd_q >= 5'd1) && ({1'b0, sd_q} <= days_in_month(sm_q, s_leap));

    // Next-state logic: day advance in RUN, iterative mod-400/mod-100 for sets.
    always_comb begin
        state_d = state_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        r400_d  = r400_q;
        r100_d  = r100_q;
        sd_d    = sd_q;
        sm_d    = sm_q;
        sy_d    = sy_q;
        sr_d    = sr_q;
        s400_d  = s400_q;
        s100_d  = s100_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        mw_d    = 1'b0;
        yw_d    = 1'b0;
        case (state_q)
            RUN: begin
                if (set_req) begin
                    // A coincident tick is intentionally discarded.
                    sd_d    = set_day;
                    sm_d    = set_month;
                    sy_d    = set_year;
                    sr_d    = set_year;
                    busy_d  = 1'b1;
                    state_d = DIV400;
                end else if (tick) begin
                    if ({1'b0, day_q} < dim) begin
                        day_d = day_q + 5'd1;
                    end else if (month_q < 4'd12) begin
                        day_d   = 5'd1;
                        month_d = month_q + 4'd1;
                        mw_d    = 1'b1;
                    end else begin
                        day_d   = 5'd1;
                        month_d = 4'd1;
                        mw_d    = 1'b1;
                        yw_d    = 1'b1;
                        if (year_q == 14'd9999) begin
                            year_d = 14'd1;
                            r400_d = 9'd1;
                            r100_d = 7'd1;
                        end else begin
                            year_d = year_q + 14'd1;
                            r400_d = (r400_q == 9'd399) ? 9'd0 : r400_q + 9'd1;
                            r100_d = (r100_q == 7'd99)  ? 7'd0 : r100_q + 7'd1;
                        end
                    end
                end
            end
            DIV400: begin
                if (sr_q >= 14'd400) begin
                    sr_d = sr_q - 14'd400;
                end else begin
                    s400_d  = sr_q[8:0];
                    state_d = DIV100;
                end
            end
            DIV100: begin
                if (sr_q >= 14'd100) begin
                    sr_d = sr_q - 14'd100;
                end else begin
                    s100_d  = sr_q[6:0];
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (s_valid) begin
                    day_d   = sd_q;
                    month_d = sm_q;
                    year_d  = sy_q;
                    r400_d  = s400_q;
                    r100_d  = s100_q;
                    ack_d   = 1'b1;
                end else begin
                    err_d   = 1'b1;
                end
                busy_d  = 1'b0;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset to 1 Jan 2000.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            day_q   <= 5'd1;
            month_q <= 4'd1;
            year_q  <= 14'd2000;
            r400_q  <= 9'd0;
            r100_q  <= 7'd0;
            sd_q    <= 5'd0;
            sm_q    <= 4'd0;
            sy_q    <= 14'd0;
            sr_q    <= 14'd0;
            s400_q  <= 9'd0;
            s100_q  <= 7'd0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            mw_q    <= 1'b0;
            yw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            r400_q  <= r400_d;
            r100_q  <= r100_d;
            sd_q    <= sd_d;
            sm_q    <= sm_d;
            sy_q    <= sy_d;
            sr_q    <= sr_d;
            s400_q  <= s400_d;
            s100_q  <= s100_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            mw_q    <= mw_d;
            yw_q    <= yw_d;
        end
    end

    assign day        = day_q;
    assign month      = month_q;
    assign year       = year_q;
    assign busy       = busy_q;
    assign set_ack    = ack_q;
    assign set_err    = err_q;
    assign month_wrap = mw_q;
    assign year_wrap  = yw_q;

endmodule

// File: tb/tb_calendar_date_ctrl.sv
// Directed bench for calendar_date_ctrl; inputs change and outputs are
// sampled on the falling clock edge.
module tb_calendar_date_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        set_req;
    logic [4:0]  set_day;
    logic [3:0]  set_month;
    logic [13:0] set_year;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [13:0] year;
    logic [5:0]  dim;
    logic        leap;
    logic        busy;
    logic        set_ack;
    logic        set_err;
    logic        month_wrap;
    logic        year_wrap;

    int n_checks = 0;
    int n_pass   = 0;

    calendar_date_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .set_req(set_req),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .day(day), .month(month), .year(year), .dim(dim), .leap(leap),
        .busy(busy), .set_ack(set_ack), .set_err(set_err),
        .month_wrap(month_wrap), .year_wrap(year_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_date(input string tag, input int d, input int m, input int y);
        check({tag, ".day"},   32'(day),   32'(d));
        check({tag, ".month"}, 32'(month), 32'(m));
        check({tag, ".year"},  32'(year),  32'(y));
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Issue one set; optionally hammer tick and a stray set_req while busy.
    task automatic do_set(input string tag, input int d, input int m, input int y,
                          input bit noisy, input bit exp_ack, input int exp_lat);
        int cnt;
        @(negedge clk);
        set_day   = 5'(d);
        set_month = 4'(m);
        set_year  = 14'(y);
        set_req   = 1'b1;
        tick      = noisy;
        @(negedge clk);
        set_req = 1'b0;
        tick    = 1'b0;
        cnt     = 0;
        check({tag, ".busy_rise"}, 32'(busy), 32'(1));
        while (!(set_ack || set_err) && cnt < 60) begin
            if (noisy) begin
                tick    = 1'b1;
                set_req = (cnt == 2);
                if (cnt == 2) begin
                    set_day   = 5'd20;
                    set_month = 4'd7;
                    set_year  = 14'd2011;
                end
            end
            @(negedge clk);
            cnt++;
        end
        tick    = 1'b0;
        set_req = 1'b0;
        check({tag, ".latency"}, 32'(cnt), 32'(exp_lat));
        check({tag, ".ack"}, 32'(set_ack), 32'(exp_ack));
        check({tag, ".err"}, 32'(set_err), 32'(!exp_ack));
        check({tag, ".busy_fall"}, 32'(busy), 32'(0));
        @(negedge clk);
        check({tag, ".pulse_one_cycle"}, 32'({set_ack, set_err}), 32'(0));
    endtask

    initial begin
        int hits;
        rst = 1'b1; tick = 1'b0; set_req = 1'b0;
        set_day = '0; set_month = '0; set_year = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_date("reset", 1, 1, 2000);
        check("reset.leap", 32'(leap), 32'(1));
        check("reset.dim",  32'(dim),  32'(31));
        check("reset.busy", 32'(busy), 32'(0));
        check("reset.pulses", 32'({set_ack, set_err, month_wrap, year_wrap}), 32'(0));

        // 59 ticks from 1 Jan 2000 reach 29 Feb 2000
        for (int i = 0; i < 59; i++) do_tick();
        check_date("feb29", 29, 2, 2000);
        check("feb29.leap", 32'(leap), 32'(1));
        check("feb29.dim",  32'(dim),  32'(29));
        do_tick();
        check_date("mar1", 1, 3, 2000);
        check("mar1.mwrap", 32'(month_wrap), 32'(1));
        check("mar1.ywrap", 32'(year_wrap),  32'(0));
        check("mar1.dim",   32'(dim),        32'(31));

        // 1900: q400=4, q100=3 -> 10 edges; not a leap year
        do_set("set1900", 28, 2, 1900, 1'b0, 1'b1, 10);
        check_date("set1900", 28, 2, 1900);
        check("set1900.leap", 32'(leap), 32'(0));
        check("set1900.dim",  32'(dim),  32'(28));
        do_tick();
        check_date("mar1_1900", 1, 3, 1900);
        check("mar1_1900.mwrap", 32'(month_wrap), 32'(1));

        // 2099 -> 2100: r100 wraps to 0, r400 is 100, so not leap
        do_set("set2099", 31, 12, 2099, 1'b0, 1'b1, 8);
        do_tick();
        check_date("y2100", 1, 1, 2100);
        check("y2100.ywrap", 32'(year_wrap), 32'(1));
        check("y2100.leap",  32'(leap),      32'(0));

        // 1999 -> 2000: both residues wrap to 0, leap
        do_set("set1999", 31, 12, 1999, 1'b0, 1'b1, 10);
        do_tick();
        check_date("y2000", 1, 1, 2000);
        check("y2000.leap", 32'(leap), 32'(1));

        // 9999 -> 0001: q400=24, q100=3 -> 30 edges
        do_set("set9999", 31, 12, 9999, 1'b0, 1'b1, 30);
        check_date("set9999", 31, 12, 9999);
        do_tick();
        check_date("y1", 1, 1, 1);
        check("y1.mwrap", 32'(month_wrap), 32'(1));
        check("y1.ywrap", 32'(year_wrap),  32'(1));
        check("y1.leap",  32'(leap),       32'(0));

        do_set("set2024", 29, 2, 2024, 1'b0, 1'b1, 8);
        check_date("set2024", 29, 2, 2024);
        check("set2024.leap", 32'(leap), 32'(1));
        check("set2024.dim",  32'(dim),  32'(29));

        // Rejected sets leave 29/2/2024 in place
        do_set("bad_apr31", 31, 4, 2023, 1'b0, 1'b0, 8);
        check_date("bad_apr31", 29, 2, 2024);
        do_set("bad_m13", 5, 13, 2023, 1'b0, 1'b0, 8);
        do_set("bad_feb29", 29, 2, 2023, 1'b0, 1'b0, 8);
        do_set("bad_day0", 0, 3, 2023, 1'b0, 1'b0, 8);
        do_set("bad_y0", 1, 1, 0, 1'b0, 1'b0, 3);
        do_set("bad_ymax", 1, 1, 16383, 1'b0, 1'b0, 46);
        check_date("after_bad", 29, 2, 2024);

        // Ticks and a stray set_req around a busy set are all dropped
        do_set("noisy", 15, 6, 2010, 1'b1, 1'b1, 8);
        check_date("noisy", 15, 6, 2010);

        // Reset three edges into a set of 8000 aborts it silently
        @(negedge clk);
        set_day = 5'd1; set_month = 4'd1; set_year = 14'd8000;
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_date("rst_mid", 1, 1, 2000);
        check("rst_mid.busy", 32'(busy), 32'(0));
        hits = 0;
        for (int i = 0; i < 60; i++) begin
            if (set_ack || set_err) hits++;
            @(negedge clk);
        end
        check("rst_mid.no_pulse", 32'(hits), 32'(0));
        check_date("rst_mid_after", 1, 1, 2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
